// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: hex glyph table
// (active-high, {g,f,e,d,c,b,a}) and polarity helpers for the idle pin levels.
package seg7_pkg;

    localparam logic [6:0] HEX_SEG_TABLE [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_off(input bit active_low);
        return active_low ? 7'h7F : 7'h00;
    endfunction

    function automatic logic anode_off(input bit active_low);
        return active_low;
    endfunction

    function automatic logic dp_off(input bit active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-high segment pattern; a blanked digit yields all segments off.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = HEX_SEG_TABLE[i_nibble];
        if (i_blank) begin
            o_seg = 7'h00;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed hex display driver: slot counter with dead time and PWM
// on-window, double-buffered digit data, leading-zero blanking, registered pins.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int TICK_DIV         = 1024,
    parameter int DEAD_CYCLES      = 16,
    parameter int DIM_BITS         = 3,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       data_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    input  logic                          lz_blank,
    input  logic [DIM_BITS-1:0]           brightness,
    input  logic                          load,
    output logic [NUM_DIGITS-1:0]         seg_anode,
    output logic [6:0]                    seg_cathode,
    output logic                          seg_dp,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int W_UNIT = (TICK_DIV - DEAD_CYCLES) >> DIM_BITS;

    localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF_V = {NUM_DIGITS{anode_off(ANODE_ACTIVE_LOW)}};
    localparam logic [6:0]            SEG_OFF_V   = seg_off(SEG_ACTIVE_LOW);
    localparam logic                  DP_OFF_V    = dp_off(SEG_ACTIVE_LOW);

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_digit_idx;
    logic [DIM_BITS-1:0]     r_bri_s;

    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic                    r_pend_valid;
    logic [4*NUM_DIGITS-1:0] r_act_data;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [DIM_BITS-1:0]     w_bri;
    logic                    w_on;
    logic [NUM_DIGITS-1:0]   w_lz_dark;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_nib;
    logic                    w_dark;
    logic                    w_dp_lit;
    logic [6:0]              w_seg;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_digit_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_digit_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt       <= '0;
            r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The live input is used on the cnt==0 cycle itself so a zero dead time still sees it.
    assign w_bri = (r_cnt == '0) ? brightness : r_bri_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bri_s <= '0;
        end else begin
            r_bri_s <= w_bri;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_valid <= 1'b0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
        end else if (w_frame_end) begin
            // A load landing on the frame boundary bypasses pending straight into active.
            if (load) begin
                r_act_data  <= data_in;
                r_act_dp    <= dp_in;
                r_act_blank <= blank_mask;
            end else if (r_pend_valid) begin
                r_act_data  <= r_pend_data;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
            end
            r_pend_valid <= 1'b0;
        end else if (load) begin
            r_pend_data  <= data_in;
            r_pend_dp    <= dp_in;
            r_pend_blank <= blank_mask;
            r_pend_valid <= 1'b1;
        end
    end

    // Leading-zero run from the top digit down; digit 0 always stays visible.
    always_comb begin
        logic v_run;
        v_run     = lz_blank;
        w_lz_dark = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_run        = v_run && (r_act_data[4*i +: 4] == 4'h0);
            w_lz_dark[i] = v_run;
        end
    end

    always_comb begin
        w_nib    = 4'h0;
        w_dark   = 1'b0;
        w_dp_lit = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_nib       = r_act_data[4*i +: 4];
                w_dark      = r_act_blank[i] | w_lz_dark[i];
                w_dp_lit    = r_act_dp[i] & ~r_act_blank[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        int v_end;
        v_end = DEAD_CYCLES + (int'(w_bri) + 1) * W_UNIT;
        w_on  = (int'(r_cnt) >= DEAD_CYCLES) && (int'(r_cnt) < v_end);
    end

    seg7_hex_decode u_decode (
        .i_nibble (w_nib),
        .i_blank  (w_dark),
        .o_seg    (w_seg)
    );

    // XOR with the idle level converts active-high internals to pin polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_anode   <= ANODE_OFF_V;
            seg_cathode <= SEG_OFF_V;
            seg_dp      <= DP_OFF_V;
            digit_idx   <= '0;
            frame_done  <= 1'b0;
        end else begin
            digit_idx  <= r_digit_idx;
            frame_done <= w_frame_end;
            if (w_on) begin
                seg_anode   <= w_onehot ^ ANODE_OFF_V;
                seg_cathode <= w_seg ^ SEG_OFF_V;
                seg_dp      <= w_dp_lit ^ DP_OFF_V;
            end else begin
                seg_anode   <= ANODE_OFF_V;
                seg_cathode <= SEG_OFF_V;
                seg_dp      <= DP_OFF_V;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: per-slot observations compared against an expected queue.
module tb_seg7_scan_mux;

    localparam int ND = 4;
    localparam int TD = 16;
    localparam int DC = 4;
    localparam int DB = 2;

    logic            clk;
    logic            rst_n;
    logic [4*ND-1:0] data_in;
    logic [ND-1:0]   dp_in;
    logic [ND-1:0]   blank_mask;
    logic            lz_blank;
    logic [DB-1:0]   brightness;
    logic            load;
    logic [ND-1:0]   seg_anode;
    logic [6:0]      seg_cathode;
    logic            seg_dp;
    logic [1:0]      digit_idx;
    logic            frame_done;

    int n_checks;
    int n_fail;

    // {anode, cathode, dp, idx, first_lit_cnt[4:0], lit_cycles[4:0], clean}
    logic [24:0] exp_q[$];

    seg7_scan_mux #(
        .NUM_DIGITS       (ND),
        .TICK_DIV         (TD),
        .DEAD_CYCLES      (DC),
        .DIM_BITS         (DB),
        .ANODE_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW   (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .blank_mask  (blank_mask),
        .lz_blank    (lz_blank),
        .brightness  (brightness),
        .load        (load),
        .seg_anode   (seg_anode),
        .seg_cathode (seg_cathode),
        .seg_dp      (seg_dp),
        .digit_idx   (digit_idx),
        .frame_done  (frame_done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic [24:0] exp_slot(input int d, input logic [3:0] nib, input logic dark,
                                             input logic dp_lit, input int lit);
        logic [6:0] seg;
        logic [3:0] an;
        seg = dark ? 7'h00 : hex_seg(nib);
        an  = ~(4'b0001 << d);
        return {an, ~seg, ~dp_lit, 2'(d), 5'(DC), 5'(lit), 1'b1};
    endfunction

    // Pushes one frame of expectations; dark/dp_lit are the hand-derived per-digit results.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dark, input logic [3:0] dp_lit,
                              input int lit);
        for (int i = 0; i < ND; i++) begin
            exp_q.push_back(exp_slot(i, d[4*i +: 4], dark[i], dp_lit[i], lit));
        end
    endtask

    // driver tasks
    task automatic drive_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        data_in    = d;
        dp_in      = dp;
        blank_mask = bl;
        load       = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        if (frame_done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_frame: frame_done=%b after %0d cycles, required 1", frame_done, n);
        end
    endtask

    // Samples one 16-cycle slot; sample i shows the pin state for cnt==i.
    task automatic observe_slot(input int bri_at, input logic [1:0] bri_val, input int load_at,
                                input logic [15:0] ld_data, output logic [24:0] obs);
        logic [3:0] an;
        logic [6:0] ca;
        logic       dp;
        logic [1:0] ix;
        int         start;
        int         cnt;
        logic       clean;
        an = 4'hF; ca = 7'h7F; dp = 1'b1; ix = 2'd0; start = 31; cnt = 0; clean = 1'b1;
        for (int i = 0; i < TD; i++) begin
            @(negedge clk);
            if (load) load = 1'b0;
            if (i == bri_at) brightness = bri_val;
            if (i == load_at) begin
                data_in = ld_data; dp_in = 4'h0; blank_mask = 4'h0; load = 1'b1;
            end
            if (seg_anode !== 4'hF) begin
                if (cnt == 0) begin
                    an = seg_anode; ca = seg_cathode; dp = seg_dp; ix = digit_idx; start = i;
                end else if (seg_anode !== an || seg_cathode !== ca || seg_dp !== dp) begin
                    clean = 1'b0;
                end
                cnt++;
            end else if (seg_cathode !== 7'h7F || seg_dp !== 1'b1) begin
                clean = 1'b0;
            end
        end
        obs = {an, ca, dp, ix, 5'(start), 5'(cnt), clean};
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (37) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (seg_anode !== 4'hF) begin n_fail++; $display("FAIL rst_anode: got %h required f", seg_anode); end
        n_checks++;
        if (seg_cathode !== 7'h7F) begin n_fail++; $display("FAIL rst_cathode: got %h required 7f", seg_cathode); end
        n_checks++;
        if (seg_dp !== 1'b1) begin n_fail++; $display("FAIL rst_dp: got %b required 1", seg_dp); end
        n_checks++;
        if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL rst_idx: got %0d required 0", digit_idx); end
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (seg_anode === 4'hF && n < 40);
        n_checks++;
        if (n != DC + 1) begin n_fail++; $display("FAIL rst_first_lit_latency: got %0d cycles required %0d", n, DC + 1); end
        n_checks++;
        if (seg_anode !== 4'b1110 || digit_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_first_digit: anode %b idx %0d required 1110 idx 0", seg_anode, digit_idx);
        end
        n_checks++;
        if (seg_cathode !== 7'h40) begin n_fail++; $display("FAIL rst_zero_glyph: got %h required 40", seg_cathode); end
    endtask

    task automatic test_scan();
        logic [24:0] obs;
        logic [24:0] exp;
        drive_load(16'h12AF, 4'b0101, 4'b0000);
        push_frame(16'h12AF, 4'b0000, 4'b0101, 12);
        wait_frame();
        for (int d = 0; d < ND; d++) begin
            observe_slot(-1, 2'd0, -1, 16'h0, obs);
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL scan_d%0d: got %h required %h", d, obs, exp); end
        end
    endtask

    task automatic test_brightness();
        logic [24:0] obs;
        logic [24:0] exp;
        brightness = 2'd0;
        push_frame(16'h12AF, 4'b0000, 4'b0101, 3);
        wait_frame();
        for (int d = 0; d < ND; d++) begin
            observe_slot(-1, 2'd0, -1, 16'h0, obs);
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL bright0_d%0d: got %h required %h", d, obs, exp); end
        end
        exp_q.push_back(exp_slot(0, 4'hF, 1'b0, 1'b1, 3));
        exp_q.push_back(exp_slot(1, 4'hA, 1'b0, 1'b0, 9));
        for (int d = 0; d < 2; d++) begin
            observe_slot((d == 0) ? 6 : -1, 2'd2, -1, 16'h0, obs);
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL bright_change_d%0d: got %h required %h", d, obs, exp); end
        end
        brightness = 2'd3;
    endtask

    task automatic test_lz_blank();
        logic [24:0] obs;
        logic [24:0] exp;
        logic [15:0] pat_d  [3];
        logic [3:0]  pat_dp [3];
        logic [3:0]  pat_bl [3];
        logic [3:0]  pat_dk [3];
        logic [3:0]  pat_dl [3];
        pat_d[0] = 16'h0005; pat_dp[0] = 4'b1000; pat_bl[0] = 4'b0000; pat_dk[0] = 4'b1110; pat_dl[0] = 4'b1000;
        pat_d[1] = 16'h0000; pat_dp[1] = 4'b0000; pat_bl[1] = 4'b0000; pat_dk[1] = 4'b1110; pat_dl[1] = 4'b0000;
        pat_d[2] = 16'h0105; pat_dp[2] = 4'b0001; pat_bl[2] = 4'b0001; pat_dk[2] = 4'b1001; pat_dl[2] = 4'b0000;
        lz_blank = 1'b1;
        for (int p = 0; p < 3; p++) begin
            drive_load(pat_d[p], pat_dp[p], pat_bl[p]);
            push_frame(pat_d[p], pat_dk[p], pat_dl[p], 12);
            wait_frame();
            for (int d = 0; d < ND; d++) begin
                observe_slot(-1, 2'd0, -1, 16'h0, obs);
                exp = exp_q.pop_front();
                n_checks++;
                if (obs !== exp) begin n_fail++; $display("FAIL lz_p%0d_d%0d: got %h required %h", p, d, obs, exp); end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_double_buffer();
        logic [24:0] obs;
        logic [24:0] exp;
        drive_load(16'h4321, 4'b0000, 4'b0000);
        push_frame(16'h4321, 4'b0000, 4'b0000, 12);
        wait_frame();
        for (int s = 0; s < 2 * ND; s++) begin
            if (s == 0)      observe_slot(-1, 2'd0, 6, 16'h1111, obs);
            else if (s == 1) observe_slot(-1, 2'd0, 3, 16'h2222, obs);
            else             observe_slot(-1, 2'd0, -1, 16'h0, obs);
            if (s == 1) push_frame(16'h2222, 4'b0000, 4'b0000, 12);
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL dbuf_s%0d: got %h required %h", s, obs, exp); end
        end
    endtask

    task automatic test_frame_start_load();
        logic [24:0] obs;
        logic [24:0] exp;
        int n;
        push_frame(16'h2222, 4'b0000, 4'b0000, 12);
        wait_frame();
        for (int s = 0; s < 2 * ND; s++) begin
            // sample 14 of the last slot is the frame-boundary cycle
            if (s == ND - 1) observe_slot(-1, 2'd0, 14, 16'h3333, obs);
            else             observe_slot(-1, 2'd0, -1, 16'h0, obs);
            if (s == ND - 1) push_frame(16'h3333, 4'b0000, 4'b0000, 12);
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL bypass_s%0d: got %h required %h", s, obs, exp); end
        end
        wait_frame();
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (frame_done !== 1'b1 && n < 200);
            n_checks++;
            if (n != ND * TD) begin n_fail++; $display("FAIL frame_period_%0d: got %0d cycles required %0d", k, n, ND * TD); end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        data_in    = '0;
        dp_in      = '0;
        blank_mask = '0;
        lz_blank   = 1'b0;
        brightness = 2'd3;
        load       = 1'b0;
        @(negedge clk);
        test_reset();
        test_scan();
        test_brightness();
        test_lz_blank();
        test_double_buffer();
        test_frame_start_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
